serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 153 +++++++++++++++
 tb/tb_serial_addsub.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub
//   Digit-serial adder/subtractor. Processes D bits per clock, least
//   significant digit first, and finishes a W-bit operation in N = W/D
//   RUN cycles. Subtraction is x + ~y + ~c_in, so c_in acts as a borrow-in.
//   The carry-out then reads 1 when no borrow occurred.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start
//   RUN    | one digit per cycle; start ignored, operands frozen
//   DONE   | results just loaded, done=1; start here begins the next op
//
// Ports
//   clk, rst_b            clock, asynchronous active-low reset
//   start, op, x, y, c_in request, 0=add/1=sub, operands, carry/borrow in
//   z, c_out, ovr         registered result, MSB carry out, signed overflow
//   busy, done            high while in RUN; one-cycle completion pulse
module serial_addsub #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         c_in,
  output logic [W-1:0] z,
  output logic         c_out,
  output logic         ovr,
  output logic         busy,
  output logic         done
);

  localparam int N  = W / D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (D < 1 || D > W || (W % D) != 0) begin : g_bad_param
    $error("serial_addsub: W must be a multiple of D with 1 <= D <= W");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   z_q, z_d;
  logic           carry_q, carry_d;
  logic           c_out_q, c_out_d;
  logic           ovr_q, ovr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [D:0]     dsum;
  logic           msb_cin;
  logic           last_digit;
  logic [W-1:0]   a_nxt, b_nxt, acc_nxt;

  // Operands shift right one digit per cycle so the active digit is always
  // the low D bits; finished digits enter the accumulator from the top, so
  // after N shifts the accumulator holds the whole result in place.
  if (D < W) begin : g_shift
    assign a_nxt   = {{D{1'b0}}, a_q[W-1:D]};
    assign b_nxt   = {{D{1'b0}}, b_q[W-1:D]};
    assign acc_nxt = {dsum[D-1:0], acc_q[W-1:D]};
  end else begin : g_single
    assign a_nxt   = '0;
    assign b_nxt   = '0;
    assign acc_nxt = dsum[D-1:0];
  end

  always_comb begin
    dsum       = {1'b0, a_q[D-1:0]} + {1'b0, b_q[D-1:0]} + {{D{1'b0}}, carry_q};
    // Carry into the digit MSB recovered from its sum bit: s = a ^ b ^ cin.
    msb_cin    = dsum[D-1] ^ a_q[D-1] ^ b_q[D-1];
    last_digit = (cnt_q == CW'(N - 1));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    z_d     = z_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = x;
          b_d     = op ? ~y : y;
          carry_d = op ^ c_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_nxt;
        b_d     = b_nxt;
        acc_d   = acc_nxt;
        carry_d = dsum[D];
        cnt_d   = cnt_q + CW'(1);
        if (last_digit) begin
          z_d     = acc_nxt;
          c_out_d = dsum[D];
          ovr_d   = dsum[D] ^ msb_cin;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      z_q     <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign z     = z_q;
  assign c_out = c_out_q;
  assign ovr   = ovr_q;
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub
//   Drives three serial_addsub instances (W=8 with D=2, D=8, D=1) from shared
//   operands and separate start lines, and compares against an integer
//   arithmetic model of add/subtract with carry, borrow and signed overflow.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [2:0] start_v;
  logic       op;
  logic       c_in;
  logic [7:0] x, y;

  logic [7:0] z_a    [3];
  logic       c_a    [3];
  logic       v_a    [3];
  logic       busy_a [3];
  logic       done_a [3];

  int checks   = 0;
  int failures = 0;
  int ns [3]   = '{4, 1, 8};
  logic [9:0] prev [3];

  always #5 clk = ~clk;

  serial_addsub #(.W(8), .D(2)) u_d2 (
    .clk(clk), .rst_b(rst_b), .start(start_v[0]), .op(op), .x(x), .y(y), .c_in(c_in),
    .z(z_a[0]), .c_out(c_a[0]), .ovr(v_a[0]), .busy(busy_a[0]), .done(done_a[0]));
  serial_addsub #(.W(8), .D(8)) u_d8 (
    .clk(clk), .rst_b(rst_b), .start(start_v[1]), .op(op), .x(x), .y(y), .c_in(c_in),
    .z(z_a[1]), .c_out(c_a[1]), .ovr(v_a[1]), .busy(busy_a[1]), .done(done_a[1]));
  serial_addsub #(.W(8), .D(1)) u_d1 (
    .clk(clk), .rst_b(rst_b), .start(start_v[2]), .op(op), .x(x), .y(y), .c_in(c_in),
    .z(z_a[2]), .c_out(c_a[2]), .ovr(v_a[2]), .busy(busy_a[2]), .done(done_a[2]));

  // Returns {c_out, ovr, z}.
  function automatic logic [9:0] model(input logic o, input logic [7:0] a, input logic [7:0] b,
                                       input logic ci);
    int ua, ub, sa, sb, u, s;
    logic co, ov;
    logic [7:0] r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!o) begin
      u  = ua + ub + int'(ci);
      s  = sa + sb + int'(ci);
      co = (u > 255);
    end else begin
      u  = ua - ub - int'(ci);
      s  = sa - sb - int'(ci);
      co = (u >= 0);
    end
    ov = (s > 127) || (s < -128);
    r  = u[7:0];
    return {co, ov, r};
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=0x%0h expected=0x%0h", tag, i, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input int i, input logic [9:0] e);
    chk({tag, "_z"}, i, 32'(z_a[i]), 32'(e[7:0]));
    chk({tag, "_cout"}, i, 32'(c_a[i]), 32'(e[9]));
    chk({tag, "_ovr"}, i, 32'(v_a[i]), 32'(e[8]));
  endtask

  // Launch one operation on all instances; optionally re-assert start on
  // the D=2 and D=1 instances in RUN cycles 2-3 with different operands.
  task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input bit inject);
    logic [9:0] e;
    int first [3];
    int dcnt  [3];
    int bcnt  [3];
    e = model(o, a, b, ci);
    for (int i = 0; i < 3; i++) begin
      first[i] = -1; dcnt[i] = 0; bcnt[i] = 0;
    end
    op = o; x = a; y = b; c_in = ci; start_v = 3'b111;
    @(posedge clk); #1;
    start_v = 3'b000;
    x = ~a; y = b ^ 8'h5A; op = ~o; c_in = ~ci;
    for (int k = 0; k < 12; k++) begin
      if (k == 0)
        for (int i = 0; i < 3; i++) chk_result("hold", i, prev[i]);
      start_v = (inject && (k == 1 || k == 2)) ? 3'b101 : 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (busy_a[i]) bcnt[i]++;
        if (done_a[i]) begin
          dcnt[i]++;
          if (first[i] < 0) begin
            first[i] = k;
            chk_result("res", i, e);
          end
        end
      end
      @(posedge clk); #1;
    end
    start_v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      chk("done_latency", i, 32'(first[i]), 32'(ns[i]));
      chk("done_count", i, 32'(dcnt[i]), 32'd1);
      chk("busy_cycles", i, 32'(bcnt[i]), 32'(ns[i]));
      chk_result("after", i, e);
      prev[i] = e;
    end
  endtask

  // Back-to-back on a single instance: second start lands in the DONE cycle.
  task automatic b2b(input int idx, input logic o1, input logic [7:0] a1, input logic [7:0] b1,
                     input logic ci1, input logic o2, input logic [7:0] a2, input logic [7:0] b2,
                     input logic ci2);
    logic [9:0] e1, e2;
    int k;
    e1 = model(o1, a1, b1, ci1);
    e2 = model(o2, a2, b2, ci2);
    op = o1; x = a1; y = b1; c_in = ci1; start_v = 3'b000; start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v = 3'b000;
    x = ~a1; y = ~b1;
    k = 0;
    while (!done_a[idx] && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("b2b_first_latency", idx, 32'(k), 32'(ns[idx]));
    chk_result("b2b_first", idx, e1);
    op = o2; x = a2; y = b2; c_in = ci2; start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v = 3'b000;
    x = ~a2; y = ~b2;
    chk("b2b_no_gap_busy", idx, 32'(busy_a[idx]), 32'd1);
    k = 1;
    while (!done_a[idx] && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    chk("b2b_spacing", idx, 32'(k), 32'(ns[idx] + 1));
    chk_result("b2b_second", idx, e2);
    repeat (3) begin
      @(posedge clk); #1;
    end
    prev[idx] = e2;
  endtask

  initial begin
    rst_b = 1'b0; start_v = 3'b000; op = 1'b0; c_in = 1'b0; x = '0; y = '0;
    for (int i = 0; i < 3; i++) prev[i] = '0;
    #3;
    for (int i = 0; i < 3; i++) begin
      chk_result("reset", i, 10'd0);
      chk("reset_busy", i, 32'(busy_a[i]), 32'd0);
      chk("reset_done", i, 32'(done_a[i]), 32'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_b = 1'b1;

    // Directed arithmetic cases.
    run_op(1'b0, 8'h0F, 8'h01, 1'b0, 1'b0);
    run_op(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(1'b0, 8'h83, 8'hFB, 1'b0, 1'b0);
    run_op(1'b1, 8'h02, 8'h83, 1'b0, 1'b0);
    run_op(1'b1, 8'h10, 8'h01, 1'b1, 1'b0);
    run_op(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op(1'b1, 8'h80, 8'h01, 1'b0, 1'b0);
    run_op(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);

    // Start re-asserted mid-RUN must be ignored.
    run_op(1'b0, 8'h3C, 8'h55, 1'b1, 1'b1);

    // Randomised operations.
    for (int n = 0; n < 24; n++)
      run_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    // Back-to-back on each digit width with identical operand pairs.
    for (int i = 0; i < 3; i++)
      b2b(i, 1'b0, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h02, 8'h83, 1'b0);

    // Reset in the middle of RUN.
    op = 1'b0; x = 8'h12; y = 8'h34; c_in = 1'b0; start_v = 3'b111;
    @(posedge clk); #1;
    start_v = 3'b000;
    @(posedge clk); #1;
    rst_b = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_result("midrun_reset", i, 10'd0);
      chk("midrun_reset_busy", i, 32'(busy_a[i]), 32'd0);
      chk("midrun_reset_done", i, 32'(done_a[i]), 32'd0);
      prev[i] = '0;
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 3; i++)
        chk("post_reset_no_done", i, 32'(done_a[i] | busy_a[i]), 32'd0);
      @(posedge clk); #1;
    end
    run_op(1'b1, 8'h10, 8'h01, 1'b1, 1'b0);
    run_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
